seven_seg_scanner: RTL and testbench
====================================

SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 Parameter NUM_DIGITS, default 8: number of multiplexed digits; legal range 1..8.
REQ-002 Parameter REFRESH_DIV, default 100000: clk cycles per digit slot; SHALL be >= BLANK_CYCLES+2.
REQ-003 Parameter BLANK_CYCLES, default 2: cycles at the start of each slot with all anodes off (anti-ghosting).
REQ-004 Parameter LZ_BLANK, default 1: 1 = leading-zero blanking enabled; 0 = disabled.
REQ-005 Clocking: one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  system clock; all state changes on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 enable  input  1  1 = display driven; 0 = all anodes off, counters keep running.
REQ-009 load  input  1  single-cycle strobe that captures value, dp_mask and neg_mask.
REQ-010 value  input  4*NUM_DIGITS  hex nibbles; nibble i drives digit i (digit 0 = rightmost).
REQ-011 dp_mask  input  NUM_DIGITS  bit i = 1 lights the decimal point of digit i.
REQ-012 neg_mask  input  NUM_DIGITS  bit i = 1 shows a minus sign on digit i (overrides the nibble).
REQ-013 seg  output  7  active-low cathodes; bit6..bit0 = CA,CB,CC,CD,CE,CF,CG.
REQ-014 dp  output  1  active-low decimal-point cathode.
REQ-015 an  output  NUM_DIGITS  active-low anodes, one-hot-low when a digit is lit.
REQ-016 frame_tick  output  1  one-cycle pulse when the digit index wraps to 0.
REQ-017 update_pending  output  1  high while loaded data waits for the frame boundary.

Function
REQ-018 Prescaler pcnt SHALL count 0..REFRESH_DIV-1 and wrap; when it wraps, digit index idx SHALL increment, and SHALL wrap from NUM_DIGITS-1 to 0.
REQ-019 frame_tick SHALL be asserted for exactly the one cycle following the edge at which idx wraps to 0.
REQ-020 On load, value/dp_mask/neg_mask SHALL be captured into pending registers and update_pending set; a later load before commit SHALL overwrite the pending data.
REQ-021 Pending data SHALL be copied to the active registers only on the edge where idx wraps to 0, which also clears update_pending; a display frame never mixes old and new data.
REQ-022 If load coincides with the commit edge, the incoming inputs SHALL be committed directly and update_pending SHALL remain 0.
REQ-023 Digit pattern for nibble 0..F SHALL be, in order: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100, 0001000, 1100000, 0110001, 1000010, 0110000, 0111000.
REQ-024 A digit with neg_mask set SHALL show 1111110; blanked digits SHALL show 1111111.
REQ-025 With LZ_BLANK=1, digit i>0 SHALL be blanked when it and all higher active nibbles are 0 and none of those digits has its dp or neg bit set; digit 0 is never blanked.
REQ-026 seg, dp and an SHALL be registered and reflect idx/pcnt with exactly one cycle of latency.
REQ-027 an SHALL be all ones when enable=0 or pcnt < BLANK_CYCLES; otherwise bit idx SHALL be 0 and all other bits 1.
REQ-028 dp SHALL equal the inverse of the active dp_mask bit for idx; it is blanked together with seg (1) while an is all ones.
REQ-029 NUM_DIGITS=1 SHALL be legal: idx stays 0 and frame_tick pulses every REFRESH_DIV cycles.

Reset
REQ-030 While reset=1: pcnt=0, idx=0, active and pending registers=0, update_pending=0, frame_tick=0, an=all ones, seg=1111111, dp=1.
REQ-031 reset SHALL dominate load and enable; reset mid-frame SHALL discard pending data, and scanning SHALL restart at digit 0 on the first cycle after release.

Verification (NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1, LZ_BLANK=1 unless stated)
REQ-032 Reset, then load value=16'h1234 and wait one frame -> an cycles 1110,1101,1011,0111 with seg 1001100, 0000110, 0010010, 1001111, each preceded by one cycle of an=1111.
REQ-033 Load 16'h0050 -> digits 3 and 2 blank (seg 1111111, an still one-hot), digit 1 = 0100100, digit 0 = 0000001; with LZ_BLANK=0, digits 3 and 2 show 0000001.
REQ-034 Load mid-frame -> update_pending=1 and old data is displayed until idx wraps; new data appears from digit 0, update_pending falls and frame_tick pulses once.
REQ-035 Load on the exact commit edge -> new data is shown in the same frame and update_pending never rises; a second load before commit -> only the last data is displayed.
REQ-036 neg_mask=4'b1000, dp_mask=4'b0010, value=0 -> digit 3 = 1111110, digit 1 has dp=0, and digits 2 and 1 are not blanked.
REQ-037 enable=0 for one frame -> an=1111 throughout while frame_tick still pulses; reset asserted mid-slot -> all outputs at reset values on the next edge.

Source files
------------

// File: rtl/seven_seg_scanner.sv
// Multiplexed seven-segment scanner: prescaled digit rotation, anti-ghost blanking,
// leading-zero suppression and frame-aligned double-buffered display data.
module seven_seg_scanner #(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 2,
  parameter int LZ_BLANK     = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [NUM_DIGITS-1:0]   neg_mask,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick,
  output logic                    update_pending
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PMAX = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IMAX = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]           pcnt_q, pcnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] act_val_q, act_val_d, pend_val_q, pend_val_d;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
  logic [NUM_DIGITS-1:0]   act_neg_q, act_neg_d, pend_neg_q, pend_neg_d;
  logic                    pend_q, pend_d;
  logic                    frame_tick_q, frame_tick_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;

  logic                    pcnt_wrap, idx_wrap, commit, blank, run;
  logic [NUM_DIGITS-1:0]   lz_run;
  logic [3:0]              nib;

  function automatic logic [6:0] seg_pattern(input logic [3:0] n);
    case (n)
      4'h0: seg_pattern = 7'b0000001;
      4'h1: seg_pattern = 7'b1001111;
      4'h2: seg_pattern = 7'b0010010;
      4'h3: seg_pattern = 7'b0000110;
      4'h4: seg_pattern = 7'b1001100;
      4'h5: seg_pattern = 7'b0100100;
      4'h6: seg_pattern = 7'b0100000;
      4'h7: seg_pattern = 7'b0001111;
      4'h8: seg_pattern = 7'b0000000;
      4'h9: seg_pattern = 7'b0000100;
      4'hA: seg_pattern = 7'b0001000;
      4'hB: seg_pattern = 7'b1100000;
      4'hC: seg_pattern = 7'b0110001;
      4'hD: seg_pattern = 7'b1000010;
      4'hE: seg_pattern = 7'b0110000;
      default: seg_pattern = 7'b0111000;
    endcase
  endfunction

  always_comb begin
    pcnt_wrap = (pcnt_q == PMAX);
    idx_wrap  = (idx_q == IMAX);
    commit    = pcnt_wrap && idx_wrap;
    pcnt_d    = pcnt_wrap ? '0 : pcnt_q + 1'b1;
    idx_d     = idx_q;
    if (pcnt_wrap) idx_d = idx_wrap ? '0 : idx_q + 1'b1;
    frame_tick_d = commit;

    // load is a one-cycle strobe; data lands in the pending buffer unless it arrives
    // on the commit edge, in which case it goes straight to the active buffer.
    act_val_d  = act_val_q;
    act_dp_d   = act_dp_q;
    act_neg_d  = act_neg_q;
    pend_val_d = pend_val_q;
    pend_dp_d  = pend_dp_q;
    pend_neg_d = pend_neg_q;
    pend_d     = pend_q;
    if (commit) begin
      pend_d = 1'b0;
      if (load) begin
        act_val_d = value;
        act_dp_d  = dp_mask;
        act_neg_d = neg_mask;
      end else if (pend_q) begin
        act_val_d = pend_val_q;
        act_dp_d  = pend_dp_q;
        act_neg_d = pend_neg_q;
      end
    end else if (load) begin
      pend_val_d = value;
      pend_dp_d  = dp_mask;
      pend_neg_d = neg_mask;
      pend_d     = 1'b1;
    end

    // lz_run[i]: digit i and every higher digit are zero with no dp or minus sign.
    run    = 1'b1;
    lz_run = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run       = run && (act_val_q[4*i +: 4] == 4'h0) && !act_dp_q[i] && !act_neg_q[i];
      lz_run[i] = run;
    end

    nib   = act_val_q[4*int'(idx_q) +: 4];
    blank = !enable || (int'(pcnt_q) < BLANK_CYCLES);
    an_d  = blank ? '1 : ~(NUM_DIGITS'(1) << idx_q);
    dp_d  = blank ? 1'b1 : !act_dp_q[idx_q];
    if (blank) seg_d = 7'b1111111;
    else if (act_neg_q[idx_q]) seg_d = 7'b1111110;
    else if ((LZ_BLANK != 0) && (idx_q != '0) && lz_run[idx_q]) seg_d = 7'b1111111;
    else seg_d = seg_pattern(nib);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt_q       <= '0;
      idx_q        <= '0;
      act_val_q    <= '0;
      act_dp_q     <= '0;
      act_neg_q    <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_neg_q   <= '0;
      pend_q       <= 1'b0;
      frame_tick_q <= 1'b0;
      seg_q        <= 7'b1111111;
      dp_q         <= 1'b1;
      an_q         <= '1;
    end else begin
      pcnt_q       <= pcnt_d;
      idx_q        <= idx_d;
      act_val_q    <= act_val_d;
      act_dp_q     <= act_dp_d;
      act_neg_q    <= act_neg_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_neg_q   <= pend_neg_d;
      pend_q       <= pend_d;
      frame_tick_q <= frame_tick_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
    end
  end

  assign seg            = seg_q;
  assign dp             = dp_q;
  assign an             = an_q;
  assign frame_tick     = frame_tick_q;
  assign update_pending = pend_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: directed and random steps checked every cycle against
// a time-based model of the scanner, with both leading-zero modes instantiated.
module tb_seven_seg_scanner;

  localparam int ND = 4;
  localparam int RD = 4;
  localparam int BC = 1;
  localparam int FRAME = ND * RD;

  logic        clk = 1'b0;
  logic        reset, enable, load;
  logic [15:0] value;
  logic [3:0]  dp_mask, neg_mask;
  logic [6:0]  seg, seg_n;
  logic        dp, dp_n, frame_tick, ft_n, update_pending, up_n;
  logic [3:0]  an, an_n;

  int checks = 0;
  int errors = 0;

  // model state: cycles since reset release plus active/pending display data
  int          m_t;
  logic [15:0] m_val, m_pval;
  logic [3:0]  m_dp, m_neg, m_pdp, m_pneg;
  logic        m_pend;

  logic [6:0] pat [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                           7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                           7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                           7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  seven_seg_scanner #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC), .LZ_BLANK(1)) dut (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .value(value),
    .dp_mask(dp_mask), .neg_mask(neg_mask), .seg(seg), .dp(dp), .an(an),
    .frame_tick(frame_tick), .update_pending(update_pending));

  seven_seg_scanner #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC), .LZ_BLANK(0)) dut_nlz (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .value(value),
    .dp_mask(dp_mask), .neg_mask(neg_mask), .seg(seg_n), .dp(dp_n), .an(an_n),
    .frame_tick(ft_n), .update_pending(up_n));

  always #5 clk = ~clk;

  function automatic bit lz_blanked(int d, logic [15:0] v, logic [3:0] dm, logic [3:0] nm);
    if (d == 0) return 1'b0;
    for (int j = d; j < ND; j++)
      if (v[4*j +: 4] != 4'h0 || dm[j] || nm[j]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic step(input logic ld, input logic [15:0] v, input logic [3:0] dm,
                      input logic [3:0] nm, input logic en, input logic rs);
    logic [3:0] e_an;
    logic [6:0] e_seg, e_seg_n;
    logic       e_dp, e_ft, c;
    int p, d;
    @(negedge clk);
    load = ld; value = v; dp_mask = dm; neg_mask = nm; enable = en; reset = rs;
    p = m_t % RD;
    d = (m_t / RD) % ND;
    c = (m_t % FRAME) == FRAME - 1;
    if (rs) begin
      e_an = 4'hF; e_seg = 7'h7F; e_seg_n = 7'h7F; e_dp = 1'b1; e_ft = 1'b0;
    end else begin
      e_ft = c;
      e_an = (!en || p < BC) ? 4'hF : ~(4'b0001 << d);
      if (e_an == 4'hF) begin
        e_seg = 7'h7F; e_seg_n = 7'h7F; e_dp = 1'b1;
      end else begin
        e_dp = ~m_dp[d];
        if (m_neg[d]) e_seg_n = 7'b1111110;
        else e_seg_n = pat[m_val[4*d +: 4]];
        e_seg = (!m_neg[d] && lz_blanked(d, m_val, m_dp, m_neg)) ? 7'h7F : e_seg_n;
      end
    end
    if (rs) begin
      m_t = 0; m_val = '0; m_dp = '0; m_neg = '0;
      m_pval = '0; m_pdp = '0; m_pneg = '0; m_pend = 1'b0;
    end else begin
      if (c) begin
        if (ld) begin m_val = v; m_dp = dm; m_neg = nm; end
        else if (m_pend) begin m_val = m_pval; m_dp = m_pdp; m_neg = m_pneg; end
        m_pend = 1'b0;
      end else if (ld) begin
        m_pval = v; m_pdp = dm; m_pneg = nm; m_pend = 1'b1;
      end
      m_t++;
    end
    @(posedge clk);
    #1;
    checks++;
    assert (an === e_an) else begin errors++; $error("FAIL an t=%0d got %b want %b", m_t, an, e_an); end
    checks++;
    assert (seg === e_seg) else begin errors++; $error("FAIL seg t=%0d got %b want %b", m_t, seg, e_seg); end
    checks++;
    assert (dp === e_dp) else begin errors++; $error("FAIL dp t=%0d got %b want %b", m_t, dp, e_dp); end
    checks++;
    assert (frame_tick === e_ft) else begin errors++; $error("FAIL frame_tick t=%0d got %b want %b", m_t, frame_tick, e_ft); end
    checks++;
    assert (update_pending === m_pend) else begin errors++; $error("FAIL update_pending t=%0d got %b want %b", m_t, update_pending, m_pend); end
    checks++;
    assert (seg_n === e_seg_n) else begin errors++; $error("FAIL seg_nolz t=%0d got %b want %b", m_t, seg_n, e_seg_n); end
    checks++;
    assert (an_n === e_an) else begin errors++; $error("FAIL an_nolz t=%0d got %b want %b", m_t, an_n, e_an); end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 4'h0, 4'h0, 1'b1, 1'b0);
  endtask

  task automatic align_commit();
    for (int i = 0; i < FRAME && (m_t % FRAME) != FRAME - 1; i++) idle(1);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; load = 1'b0; value = '0; dp_mask = '0; neg_mask = '0;
    m_t = 0; m_val = '0; m_dp = '0; m_neg = '0;
    m_pval = '0; m_pdp = '0; m_pneg = '0; m_pend = 1'b0;

    for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 4'h0, 4'h0, 1'b1, 1'b1);

    // 1234 loaded immediately after release, shown from the next frame
    step(1'b1, 16'h1234, 4'h0, 4'h0, 1'b1, 1'b0);
    checks++;
    assert (update_pending === 1'b1) else begin errors++; $error("FAIL pend_after_load got %b want 1", update_pending); end
    idle(2 * FRAME);

    // mid-frame load of 0050, plus overwrite before commit
    idle(5);
    step(1'b1, 16'h0050, 4'h0, 4'h0, 1'b1, 1'b0);
    idle(2);
    step(1'b1, 16'h0050, 4'h0, 4'h0, 1'b1, 1'b0);
    idle(2 * FRAME);

    // load on the commit edge, then double load before the next commit
    align_commit();
    step(1'b1, 16'hABCD, 4'h5, 4'h0, 1'b1, 1'b0);
    checks++;
    assert (update_pending === 1'b0) else begin errors++; $error("FAIL pend_on_commit got %b want 0", update_pending); end
    idle(FRAME + 3);
    step(1'b1, 16'h9876, 4'h0, 4'h0, 1'b1, 1'b0);
    step(1'b1, 16'h0E0F, 4'h0, 4'h0, 1'b1, 1'b0);
    idle(2 * FRAME);

    // minus sign and decimal point defeat leading-zero blanking
    step(1'b1, 16'h0000, 4'b0010, 4'b1000, 1'b1, 1'b0);
    idle(2 * FRAME);

    // display disabled for a frame
    for (int i = 0; i < FRAME + 2; i++) step(1'b0, 16'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    idle(FRAME);

    // random traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 7) == 0, 16'($urandom), 4'($urandom), 4'($urandom_range(0, 3) == 0 ? $urandom : 0),
           $urandom_range(0, 9) != 0, 1'b0);

    // reset mid-slot with pending data, then restart
    idle(6);
    step(1'b1, 16'h4321, 4'h0, 4'h0, 1'b1, 1'b0);
    step(1'b1, 16'h1111, 4'hF, 4'h0, 1'b1, 1'b1);
    step(1'b0, 16'h0, 4'h0, 4'h0, 1'b1, 1'b1);
    checks++;
    assert (update_pending === 1'b0 && an === 4'hF) else begin errors++; $error("FAIL reset_mid got up=%b an=%b want 0 1111", update_pending, an); end
    idle(2 * FRAME);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
